// File: rtl/obstacle_engine.sv
// Side-scrolling obstacle engine: lane motion, LFSR respawn, speed ramp, BCD score, collision FSM.
// Define OBSTACLE_ENGINE_HISCORE_EN to build the high-score register; otherwise hiscore_bcd reads 0.
module obstacle_engine #(
    parameter int N_OBS       = 4,
    parameter int XW          = 12,
    parameter int SCREEN_W    = 1280,
    parameter int TICK_DIV    = 2000000,
    parameter int PASS_TARGET = 12,
    parameter int SPEED_MAX   = 8,
    parameter int DIGITS      = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [XW-1:0]         player_x,
    input  logic [XW-1:0]         player_y,
    input  logic [5:0]            player_w,
    input  logic [5:0]            player_h,
    input  logic [N_OBS*XW-1:0]   obs_y,
    input  logic [N_OBS*12-1:0]   obs_wh,
    output logic [N_OBS*XW-1:0]   obs_x,
    output logic [DIGITS*4-1:0]   score_bcd,
    output logic [DIGITS*4-1:0]   hiscore_bcd,
    output logic [3:0]            speed,
    output logic                  running,
    output logic                  game_over,
    output logic                  frame_tick
);
    localparam int SW = DIGITS * 4;
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = $clog2(PASS_TARGET + N_OBS + 1);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   obs_q [N_OBS];
    logic [XW-1:0]   obs_d [N_OBS];
    logic [XW-1:0]   moved [N_OBS];
    logic [SW-1:0]   score_q, score_d;
    logic [3:0]      speed_q, speed_d;
    logic [PW-1:0]   pass_q, pass_d;
    logic [DW-1:0]   div_q, div_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [N_OBS-1:0] hit_v, wrap_v;
    logic [PW-1:0]   n_wrap;
    logic            tick, hit;

    function automatic logic [XW-1:0] home_x(input int i);
        return XW'(SCREEN_W + 128 * i);
    endfunction

    function automatic logic [XW-1:0] respawn_x(input int i, input logic [7:0] l);
        logic [7:0] key;
        key = 8'((8'h5B * i) % 256);
        return XW'(SCREEN_W) + XW'({l ^ key, 2'b00});
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (v[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [XW:0] ext6(input logic [5:0] v);
        return {{(XW-5){1'b0}}, v};
    endfunction

    // Sums are one bit wider than positions so box edges never wrap.
    always_comb begin
        hit_v  = '0;
        wrap_v = '0;
        n_wrap = '0;
        for (int i = 0; i < N_OBS; i++) begin
            hit_v[i] = (|obs_wh[i*12+6 +: 6]) && (|obs_wh[i*12 +: 6])
                && ({1'b0, player_x} < {1'b0, obs_q[i]} + ext6(obs_wh[i*12+6 +: 6]))
                && ({1'b0, player_x} + ext6(player_w) > {1'b0, obs_q[i]})
                && ({1'b0, player_y} < {1'b0, obs_y[i*XW +: XW]} + ext6(obs_wh[i*12 +: 6]))
                && ({1'b0, player_y} + ext6(player_h) > {1'b0, obs_y[i*XW +: XW]});
            wrap_v[i] = (obs_q[i] <= XW'(speed_q));
            moved[i]  = wrap_v[i] ? respawn_x(i, lfsr_q) : obs_q[i] - XW'(speed_q);
            n_wrap    = n_wrap + PW'(wrap_v[i]);
        end
    end

    assign hit  = (state_q == RUN) && (|hit_v);
    assign tick = (state_q == RUN) && (div_q == DW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        speed_d = speed_q;
        pass_d  = pass_q;
        div_d   = div_q;
        lfsr_d  = lfsr_q;
        for (int i = 0; i < N_OBS; i++) obs_d[i] = obs_q[i];
        case (state_q)
            RUN: begin
                lfsr_d = lfsr_next(lfsr_q);
                if (hit) begin
                    state_d = OVER;
                end else if (tick) begin
                    div_d   = '0;
                    score_d = bcd_inc(score_q);
                    for (int i = 0; i < N_OBS; i++) obs_d[i] = moved[i];
                    // A full pass count converts into a speed step; this tick's wraps are dropped.
                    if (pass_q >= PW'(PASS_TARGET)) begin
                        pass_d  = '0;
                        speed_d = (speed_q < 4'(SPEED_MAX)) ? speed_q + 4'd1 : 4'(SPEED_MAX);
                    end else begin
                        pass_d = pass_q + n_wrap;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            IDLE, OVER: begin
                if (start) begin
                    state_d = RUN;
                    score_d = '0;
                    speed_d = 4'd1;
                    pass_d  = '0;
                    div_d   = '0;
                    for (int i = 0; i < N_OBS; i++) obs_d[i] = home_x(i);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            score_q <= '0;
            speed_q <= 4'd1;
            pass_q  <= '0;
            div_q   <= '0;
            lfsr_q  <= 8'hA5;
            for (int i = 0; i < N_OBS; i++) obs_q[i] <= home_x(i);
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            speed_q <= speed_d;
            pass_q  <= pass_d;
            div_q   <= div_d;
            lfsr_q  <= lfsr_d;
            for (int i = 0; i < N_OBS; i++) obs_q[i] <= obs_d[i];
        end
    end

`ifdef OBSTACLE_ENGINE_HISCORE_EN
    logic [SW-1:0] hi_q;

    // Equal-length BCD vectors order the same way as their decimal values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= '0;
        end else if (hit && (score_q > hi_q)) begin
            hi_q <= score_q;
        end
    end
    assign hiscore_bcd = hi_q;
`else
    assign hiscore_bcd = '0;
`endif

    always_comb begin
        for (int i = 0; i < N_OBS; i++) obs_x[i*XW +: XW] = obs_q[i];
    end

    assign score_bcd  = score_q;
    assign speed      = speed_q;
    assign running    = (state_q == RUN);
    assign game_over  = (state_q == OVER);
    assign frame_tick = tick;
endmodule
